mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter for the single-port 16-bit data RAM.
- Port 0 serves the command processor; port 1 serves a secondary master (loader/DMA).
- Each port uses the existing block/response handshake: the master holds a level request, and the arbiter returns a one-cycle response pulse whose falling edge releases the master.
- It serialises accesses, drives the RAM port and pipelines RAM read latency.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RD_LAT, 1, RAM read latency in cycles (>=1); writes also occupy RD_LAT cycles

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req0  in  1  port 0 request (master's block flag), level
mode0  in  1  port 0 mode: 0 read, 1 write
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
rdata0  out  DATA_W  port 0 read data, held until next port-0 read completes
resp0  out  1  port 0 response pulse
req1, mode1, addr1, wdata1, rdata1, resp1  same as port 0, for port 1
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_addr
grant  out  1  index of port owning current or last transaction
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0, priority pointer favours port 0. This applies even mid-transaction; the aborted transaction gets no response, so masters must share rst.
- States:
  - IDLE: accept a request.
  - ISSUE: RAM access in flight.
  - RESP: response pulse.
  - RECOVER: single dead cycle.
- IDLE, at edge E0, with req0 or req1 sampled high:
  - Pick the port. Both high: the port not granted last (round-robin). Only one high: that port.
  - Latch mode/addr/wdata into internal registers.
  - Drive ram_addr/ram_wdata from the latches; set grant; go to ISSUE; counter <= 0.
  - For writes, ram_we = 1 for exactly the first ISSUE cycle; it is 0 in all other cycles and states.
- ISSUE: counter increments each edge. At edge E0+RD_LAT:
  - Read: rdataN <= ram_rdata.
  - respN <= 1; go to RESP.
- RESP: lasts exactly one cycle. At E0+RD_LAT+1: respN <= 0; flip the priority pointer to the other port; go to RECOVER.
- RECOVER: no request is sampled. At E0+RD_LAT+2, go to IDLE. This guarantees the master's block flag, cleared on the resp falling edge, is observed low before it can be re-accepted.
- Latency and throughput:
  - Accept to resp rise is RD_LAT cycles.
  - Minimum occupancy is RD_LAT+3 cycles per transaction.
- The non-granted port's request stays pending, not dropped, and wins the next IDLE cycle.
- respN is never high for the non-granted port; resp0 and resp1 are never high together.
- rdataN is unchanged on writes and on the other port's transactions.
- A request that drops while in ISSUE is still completed, with a response pulse; the arbiter never aborts except on rst.
- Address/data are used only as latched at accept; later input changes are ignored.
- Address wrap is the RAM's concern; no arithmetic on addresses.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum (IDLE, ISSUE, RESP, RECOVER)
  - MMODE_READ=0 and MMODE_WRITE=1, shared with command_processor
  - default ADDR_W/DATA_W
- Sub-module rr_pick2:
  - Combinational two-way round-robin chooser.
  - Inputs: req0, req1, last grant. Outputs: valid, pick.
  - Natural and reusable for the peripheral bus.
- Everything else stays in the top module.

Test Plan:
- Single read, RD_LAT=1: RAM[0x0010]=0xBEEF, req0=1, mode0=0, addr0=0x0010 → resp0 high exactly one cycle, 1 cycle after accept; rdata0=0xBEEF; resp1 stays 0.
- Single write: req1=1, mode1=1, addr1=0x00FF, wdata1=0x1234 → ram_we high exactly 1 cycle with ram_addr=0x00FF and ram_wdata=0x1234; resp1 pulses once; rdata1 unchanged.
- Contention: req0 and req1 asserted the same cycle, both held until their response → port 0 served first, then port 1 with no further stimulus; order alternates 0,1,0,1 over 4 back-to-back rounds.
- CPU-style re-request: master reasserts req0 2 cycles after resp0 falls → exactly one transaction per assertion, no duplicate grant during RECOVER; 5 sequential reads from 0x0000..0x0004 return the preloaded values in order.
- RD_LAT=3: read accepted at cycle 10 → resp0 at cycle 13, busy through cycle 15, next accept no earlier than cycle 16.
- Reset mid-ISSUE: rst asserted the cycle after accept → next edge: state IDLE, ram_we=0, resp0=resp1=0, rdata0=rdata1=0, grant=0; a fresh req0 afterwards completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the data-RAM bus.
//   - arb_state_e : arbiter FSM states
//   - MMODE_*     : master access mode encoding (shared with command_processor)
//   - Default*W   : default address/data widths
package mem_bus_pkg;

  localparam int unsigned DefaultAddrW = 16;
  localparam int unsigned DefaultDataW = 16;

  localparam logic MMODE_READ  = 1'b0;
  localparam logic MMODE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp,
    StRecover
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser.
// Ports:
//   req0_i, req1_i : request levels
//   last_i         : index of the port served most recently
//   valid_o        : at least one request present
//   pick_o         : chosen port index (meaningful only when valid_o)
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic pick_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    // On a tie the port not served last wins; otherwise the lone requester.
    if (req0_i && req1_i) begin
      pick_o = ~last_i;
    end else begin
      pick_o = req1_i;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester arbiter for the single-port data RAM.
// Serialises block/response handshakes from port 0 (command processor) and
// port 1 (loader/DMA), drives the RAM port and absorbs RAM read latency.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   reqN, modeN, addrN, wdataN : port N request level, mode, address, write data
//   rdataN, respN              : port N read data (held), one-cycle response pulse
//   ram_addr/ram_wdata/ram_we  : RAM command (registered)
//   ram_rdata                  : RAM read data, valid RD_LAT cycles after ram_addr
//   grant                      : port owning the current or last transaction
//   busy                       : high whenever the FSM is not idle
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              mode0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              resp0,
  input  logic              req1,
  input  logic              mode1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              resp1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              grant,
  output logic              busy
);

  // Counter spans 0..RD_LAT-1 while in ISSUE.
  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              last_q;
  logic              mode_q;
  logic              grant_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              resp0_q;
  logic              resp1_q;
  logic              busy_q;

  logic pick_valid;
  logic pick;

  rr_pick2 u_pick (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .pick_o  (pick)
  );

  // ram_addr_q / ram_wdata_q double as the accept-time latches, so later
  // changes on addrN/wdataN cannot leak into an access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= 1'b1;  // "port 1 served last" makes port 0 win the first tie
      mode_q      <= MMODE_READ;
      grant_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      resp0_q     <= 1'b0;
      resp1_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulsed outputs default low; each is set for exactly one cycle below.
      ram_we_q <= 1'b0;
      resp0_q  <= 1'b0;
      resp1_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q     <= pick;
            mode_q      <= pick ? mode1 : mode0;
            ram_addr_q  <= pick ? addr1 : addr0;
            ram_wdata_q <= pick ? wdata1 : wdata0;
            ram_we_q    <= (pick ? mode1 : mode0) == MMODE_WRITE;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(RD_LAT - 1)) begin
            if (mode_q == MMODE_READ) begin
              if (grant_q) begin
                rdata1_q <= ram_rdata;
              end else begin
                rdata0_q <= ram_rdata;
              end
            end
            if (grant_q) begin
              resp1_q <= 1'b1;
            end else begin
              resp0_q <= 1'b1;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          last_q  <= grant_q;
          state_q <= StRecover;
        end
        StRecover: begin
          // Dead cycle: the master's request drops after resp falls and must
          // not be mistaken for a new one.
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign resp0     = resp0_q;
  assign resp1     = resp1_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (RD_LAT=1 and RD_LAT=3).
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // RD_LAT=1 instance signals
  logic        req0 = 1'b0, mode0 = 1'b0, req1 = 1'b0, mode1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [15:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
  logic        resp0, resp1, ram_we, grant, busy;

  // RD_LAT=3 instance signals (port 1 tied off)
  logic        req0_3 = 1'b0;
  logic [15:0] addr0_3 = '0;
  logic [15:0] rdata0_3, rdata1_3, ram_addr3, ram_wdata3, ram_rdata3;
  logic        resp0_3, resp1_3, ram_we3, grant3, busy3;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .mode0(mode0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .resp0(resp0),
    .req1(req1), .mode1(mode1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .resp1(resp1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .grant(grant), .busy(busy)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(req0_3), .mode0(1'b0), .addr0(addr0_3), .wdata0(16'h0000), .rdata0(rdata0_3),
    .resp0(resp0_3),
    .req1(1'b0), .mode1(1'b0), .addr1(16'h0000), .wdata1(16'h0000), .rdata1(rdata1_3),
    .resp1(resp1_3),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_we(ram_we3), .ram_rdata(ram_rdata3),
    .grant(grant3), .busy(busy3)
  );

  // RAM model for RD_LAT=1: combinational read, write on posedge, preload port.
  logic [15:0] mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0, pl_data = '0;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // RAM model for RD_LAT=3: ROM contents addr ^ A5A5 through two register stages.
  logic [15:0] r3_s1 = '0, r3_s2 = '0;
  always @(posedge clk) begin
    r3_s1 <= ram_addr3 ^ 16'hA5A5;
    r3_s2 <= r3_s1;
  end
  assign ram_rdata3 = r3_s2;

  // Event monitors
  int r0_cnt = 0, r1_cnt = 0, we_cnt = 0, bad_cnt = 0;
  always @(posedge clk) begin
    if (resp0) r0_cnt <= r0_cnt + 1;
    if (resp1) r1_cnt <= r1_cnt + 1;
    if (ram_we) we_cnt <= we_cnt + 1;
    if ((resp0 && resp1) || (resp0 && grant) || (resp1 && !grant)) bad_cnt <= bad_cnt + 1;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Ticks until a response on the given port (0, 1, or 2 = either); cyc=0 on timeout.
  task automatic wait_resp(input int port, output int cyc, output int who);
    cyc = 0;
    who = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if ((port != 1 && resp0 === 1'b1) || (port != 0 && resp1 === 1'b1)) begin
        cyc = k;
        who = (resp1 === 1'b1) ? 1 : 0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, who, r0s, we0;

    // Reset and RAM preload
    preload(16'h0010, 16'hBEEF);
    for (int i = 0; i < 5; i++) preload(16'(i), 16'hC000 + 16'(i) * 16'h0101);
    tick();
    chk("rst_resp", 32'({resp0, resp1}), 32'd0);
    chk("rst_rdata", {rdata0, rdata1}, 32'd0);
    chk("rst_grant_busy_we", 32'({grant, busy, ram_we}), 32'd0);
    chk("rst_ram_bus", {ram_addr, ram_wdata}, 32'd0);
    rst = 1'b0;
    tick();

    // Single read, port 0
    req0 = 1'b1; mode0 = 1'b0; addr0 = 16'h0010;
    wait_resp(0, c, who);
    chk("rd_latency", 32'(c), 32'd2);
    chk("rd_rdata0", 32'(rdata0), 32'h0000BEEF);
    chk("rd_resp1_low", 32'(resp1), 32'd0);
    chk("rd_grant", 32'(grant), 32'd0);
    tick();
    req0 = 1'b0;
    chk("rd_resp_one_cycle", 32'(resp0), 32'd0);
    chk("rd_recover_busy", 32'(busy), 32'd1);
    tick();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_pulse_count", 32'(r0_cnt), 32'd1);

    // Single write, port 1
    we0 = we_cnt;
    req1 = 1'b1; mode1 = 1'b1; addr1 = 16'h00FF; wdata1 = 16'h1234;
    tick();
    chk("wr_we", 32'(ram_we), 32'd1);
    chk("wr_bus", {ram_addr, ram_wdata}, 32'h00FF1234);
    chk("wr_grant", 32'(grant), 32'd1);
    addr1 = 16'h0077; wdata1 = 16'hDEAD;  // must be ignored
    tick();
    chk("wr_we_drop", 32'(ram_we), 32'd0);
    chk("wr_bus_held", {ram_addr, ram_wdata}, 32'h00FF1234);
    chk("wr_resp1", 32'({resp1, resp0}), 32'd2);
    chk("wr_rdata1_unchanged", 32'(rdata1), 32'd0);
    tick();
    req1 = 1'b0;
    tick();
    chk("wr_we_cycles", 32'(we_cnt - we0), 32'd1);
    chk("wr_mem", 32'(mem[16'h00FF]), 32'h00001234);
    chk("wr_pulse_count", 32'(r1_cnt), 32'd1);

    // Contention: both held, expect 0,1,0,1 with RD_LAT+3 spacing
    req0 = 1'b1; mode0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; mode1 = 1'b0; addr1 = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      wait_resp(2, c, who);
      chk("cont_port", 32'(who), 32'(i % 2));
      chk("cont_spacing", 32'(c), (i == 0) ? 32'd2 : 32'd4);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_rdata0", 32'(rdata0), 32'h0000BEEF);
    chk("cont_rdata1", 32'(rdata1), 32'h00001234);
    tick();
    tick();
    chk("cont_idle", 32'(busy), 32'd0);

    // CPU-style sequential reads, re-request 2 cycles after resp falls
    r0s = r0_cnt;
    for (int i = 0; i < 5; i++) begin
      addr0 = 16'(i); mode0 = 1'b0; req0 = 1'b1;
      wait_resp(0, c, who);
      chk("cpu_latency", 32'(c), 32'd2);
      chk("cpu_rdata", 32'(rdata0), 32'hC000 + 32'(i) * 32'h0101);
      tick();
      req0 = 1'b0;
      tick();
      tick();
    end
    tick();
    chk("cpu_pulse_count", 32'(r0_cnt - r0s), 32'd5);
    chk("no_bad_resp", 32'(bad_cnt), 32'd0);

    // Reset in the first ISSUE cycle of a port-1 write
    req1 = 1'b1; mode1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h5555;
    tick();
    chk("rstmid_we", 32'({ram_we, grant}), 32'd3);
    rst = 1'b1; req1 = 1'b0;
    tick();
    chk("rstmid_ctrl", 32'({ram_we, grant, busy, resp0, resp1}), 32'd0);
    chk("rstmid_rdata", {rdata0, rdata1}, 32'd0);
    rst = 1'b0;
    tick();
    // Port 0 served last before reset, but reset must restore port-0 priority
    req0 = 1'b1; mode0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; mode1 = 1'b0; addr1 = 16'h00FF;
    wait_resp(2, c, who);
    req0 = 1'b0; req1 = 1'b0;
    chk("rstmid_fresh_port", 32'(who), 32'd0);
    chk("rstmid_fresh_lat", 32'(c), 32'd2);
    chk("rstmid_fresh_rdata", 32'(rdata0), 32'h0000BEEF);
    tick();
    tick();

    // RD_LAT=3: accept at E0, resp at E0+3, idle at E0+5, next accept E0+6
    req0_3 = 1'b1; addr0_3 = 16'h0040;
    tick();
    chk("l3_accept", {15'd0, busy3, ram_addr3}, 32'h00010040);
    addr0_3 = 16'h0041;
    tick();
    chk("l3_e1_resp", 32'(resp0_3), 32'd0);
    tick();
    chk("l3_e2_resp", 32'(resp0_3), 32'd0);
    chk("l3_addr_held", 32'(ram_addr3), 32'h00000040);
    tick();
    chk("l3_e3_resp", 32'(resp0_3), 32'd1);
    chk("l3_rdata", 32'(rdata0_3), 32'h0000A5E5);
    tick();
    chk("l3_e4", 32'({resp0_3, busy3}), 32'd1);
    tick();
    chk("l3_e5_idle", 32'(busy3), 32'd0);
    tick();
    chk("l3_e6_accept", {15'd0, busy3, ram_addr3}, 32'h00010041);
    req0_3 = 1'b0;
    tick();
    tick();
    tick();
    chk("l3_second", {15'd0, resp0_3, rdata0_3}, 32'h0001A5E4);
    chk("l3_port1_quiet", {15'd0, resp1_3, rdata1_3}, 32'd0);
    tick();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
